// File: rtl/voter_nmr.sv
// rtl/voter_nmr.sv - N-modular-redundancy word voter with per-channel fault tracking
// Registered bitwise majority over active channels; persistently disagreeing channels are excluded.
module voter_nmr #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 3,
  parameter int FAULT_LIMIT = 4,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      clear_faults,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_tie,
  output logic [CHANNELS-1:0]       mismatch,
  output logic [CHANNELS-1:0]       fault,
  output logic [CNT_W-1:0]          err_count
);

  typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTY} state_e;

  localparam logic [3:0] LIMIT = 4'(FAULT_LIMIT);

  state_e              state_q  [CHANNELS];
  state_e              state_d  [CHANNELS];
  logic [3:0]          streak_q [CHANNELS];
  logic [3:0]          streak_d [CHANNELS];

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic                out_tie_q;
  logic [CHANNELS-1:0] mismatch_q;
  logic [CNT_W-1:0]    err_q, err_d;

  logic [CHANNELS-1:0] active;
  logic [4:0]          n_active, n_left, ones;
  logic [WIDTH-1:0]    vote_d;
  logic                tie_d;
  logic [CHANNELS-1:0] mm_d;
  logic [3:0]          streak_inc;

  always_comb begin
    n_active = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      active[k] = (state_q[k] != FAULTY);
      fault[k]  = (state_q[k] == FAULTY);
      n_active  = n_active + {4'd0, active[k]};
    end
  end

  always_comb begin
    vote_d = '0;
    tie_d  = 1'b0;
    ones   = '0;
    mm_d   = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (active[k] && in_data[k*WIDTH+b]) ones = ones + 5'd1;
      end
      vote_d[b] = ({ones[3:0], 1'b0} > n_active);
      if ({ones[3:0], 1'b0} == n_active) tie_d = 1'b1;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      mm_d[k] = active[k] && (in_data[k*WIDTH +: WIDTH] != vote_d);
    end
  end

  // Channels are walked in ascending order so that, when several hit the limit
  // together, lower indices are excluded first until the two-channel floor bites.
  always_comb begin
    n_left     = n_active;
    streak_inc = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k]  = state_q[k];
      streak_d[k] = streak_q[k];
    end
    if (clear_faults) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_d[k]  = HEALTHY;
        streak_d[k] = '0;
      end
    end else if (in_valid) begin
      for (int k = 0; k < CHANNELS; k++) begin
        streak_inc = (streak_q[k] >= LIMIT) ? LIMIT : streak_q[k] + 4'd1;
        case (state_q[k])
          HEALTHY, SUSPECT: begin
            if (!mm_d[k]) begin
              state_d[k]  = HEALTHY;
              streak_d[k] = '0;
            end else begin
              streak_d[k] = streak_inc;
              if (streak_inc == LIMIT && n_left > 5'd2) begin
                state_d[k] = FAULTY;
                n_left     = n_left - 5'd1;
              end else begin
                state_d[k] = SUSPECT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (clear_faults) begin
      err_d = '0;
    end else if (in_valid && (|mm_d) && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tie_q   <= 1'b0;
      mismatch_q  <= '0;
      err_q       <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k]  <= HEALTHY;
        streak_q[k] <= '0;
      end
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= vote_d;
        out_tie_q  <= tie_d;
        mismatch_q <= mm_d;
      end
      err_q <= err_d;
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k]  <= state_d[k];
        streak_q[k] <= streak_d[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tie   = out_tie_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_voter_nmr.sv
// tb/tb_voter_nmr.sv - scoreboard bench for voter_nmr
// A reference model pushes expected results when a sample is driven; the monitor pops them on out_valid.
module tb_voter_nmr;

  localparam int LIM = 4;

  logic        clk, rst_n, in_valid, clear_faults;
  logic [23:0] in_data;
  logic        out_valid, out_tie;
  logic [7:0]  out_data, err_count;
  logic [2:0]  mismatch, fault;
  logic        s_valid, s_tie;
  logic [7:0]  s_data;
  logic [2:0]  s_mm, s_fault;
  logic [1:0]  s_err;

  voter_nmr #(.WIDTH(8), .CHANNELS(3), .FAULT_LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_faults(clear_faults), .out_valid(out_valid), .out_data(out_data),
    .out_tie(out_tie), .mismatch(mismatch), .fault(fault), .err_count(err_count)
  );

  voter_nmr #(.WIDTH(8), .CHANNELS(3), .FAULT_LIMIT(LIM), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_faults(clear_faults), .out_valid(s_valid), .out_data(s_data),
    .out_tie(s_tie), .mismatch(s_mm), .fault(s_fault), .err_count(s_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       tie;
    logic [2:0] mm;
    logic [2:0] flt;
    logic [7:0] err;
    logic [1:0] errs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  logic [2:0] m_flt;
  int         m_streak [3];
  int         m_err, m_errs;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [23:0] w3(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic model_reset();
    m_flt = '0;
    for (int k = 0; k < 3; k++) m_streak[k] = 0;
    m_err = 0;
    m_errs = 0;
  endtask

  task automatic model_push(input logic [23:0] data, input logic clr);
    int nact, cnt;
    exp_t e;
    nact = 0;
    for (int k = 0; k < 3; k++) if (!m_flt[k]) nact++;
    e.tie = 1'b0;
    for (int b = 0; b < 8; b++) begin
      cnt = 0;
      for (int k = 0; k < 3; k++) if (!m_flt[k] && data[k*8+b]) cnt++;
      e.d[b] = (2*cnt > nact);
      if (2*cnt == nact) e.tie = 1'b1;
    end
    for (int k = 0; k < 3; k++) e.mm[k] = !m_flt[k] && (data[k*8 +: 8] != e.d);
    if (clr) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!m_flt[k]) begin
          if (e.mm[k]) begin
            if (m_streak[k] < LIM) m_streak[k]++;
          end else begin
            m_streak[k] = 0;
          end
          if (m_streak[k] == LIM && nact > 2) begin
            m_flt[k] = 1'b1;
            nact--;
          end
        end
      end
      if (e.mm != 3'b000) begin
        if (m_err < 255) m_err++;
        if (m_errs < 3) m_errs++;
      end
    end
    e.flt  = m_flt;
    e.err  = 8'(m_err);
    e.errs = 2'(m_errs);
    q.push_back(e);
  endtask

  task automatic send(input logic [23:0] data, input logic clr);
    in_valid = 1'b1;
    in_data = data;
    clear_faults = clr;
    model_push(data, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    clear_faults = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.d));
        check("out_tie", 32'(out_tie), 32'(mon_e.tie));
        check("mismatch", 32'(mismatch), 32'(mon_e.mm));
        check("fault", 32'(fault), 32'(mon_e.flt));
        check("err_count", 32'(err_count), 32'(mon_e.err));
        check("err_sat", 32'(s_err), 32'(mon_e.errs));
      end
    end
  end

  initial begin
    logic [7:0] base;
    logic [7:0] ch [3];
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    clear_faults = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);

    send(w3(8'hA5, 8'hA5, 8'hA5), 1'b0);
    repeat (4) send(w3(8'h3C, 8'h3C, 8'hFF), 1'b0);
    send(w3(8'h3C, 8'h3C, 8'h00), 1'b0);
    idle();
    @(negedge clk);
    check("excluded_ch2", 32'(fault), 32'h4);
    check("hold_data", 32'(out_data), 32'h3C);
    check("err_after_limit", 32'(err_count), 32'd4);

    repeat (5) send(w3(8'hF0, 8'h0F, 8'h55), 1'b0);
    idle();
    @(negedge clk);
    check("floor_fault", 32'(fault), 32'h4);
    check("sat_err", 32'(s_err), 32'd3);

    send(w3(8'h11, 8'h22, 8'hFF), 1'b1);
    idle();
    @(negedge clk);
    check("clear_fault", 32'(fault), 32'h0);
    check("clear_err", 32'(err_count), 32'd0);

    repeat (3) send(w3(8'h00, 8'h5A, 8'h5A), 1'b0);
    send(w3(8'h5A, 8'h5A, 8'h5A), 1'b0);
    repeat (3) send(w3(8'h00, 8'h5A, 8'h5A), 1'b0);
    idle();
    @(negedge clk);
    check("streak_reset_fault", 32'(fault), 32'h0);

    for (int i = 0; i < 30; i++) begin
      base = 8'($urandom);
      for (int k = 0; k < 3; k++) ch[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
      send(w3(ch[0], ch[1], ch[2]), ($urandom_range(0, 11) == 0));
    end
    send(w3(8'h77, 8'h77, 8'h12), 1'b0);
    idle();
    idle();

    in_valid = 1'b1;
    in_data = w3(8'h01, 8'h02, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_tie", 32'(out_tie), 32'd0);
    check("arst_mm", 32'(mismatch), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_err", 32'(err_count), 32'd0);
    in_valid = 1'b0;
    model_reset();
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) idle();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/voter_nmr.md
# voter_nmr

Parametrised N-modular-redundancy word voter with registered output, per-channel fault tracking and automatic exclusion of persistently disagreeing channels. Each valid sample carries CHANNELS words of WIDTH bits; the block computes a bitwise majority over the currently active channels and flags mismatches. A channel that disagrees with the vote for FAULT_LIMIT consecutive samples is declared faulty and dropped from later votes. It sits between replicated datapaths and the downstream consumer, as the sequential successor of the 3-input combinational majority gate.

## Interface
- WIDTH, 8: bits per channel word (1..32).
- CHANNELS, 3: number of redundant channels (odd, 3..7).
- FAULT_LIMIT, 4: consecutive mismatches that make a channel faulty (1..15).
- CNT_W, 8: width of the error counter.

- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample strobe; in_data is sampled only when high.
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- clear_faults  in  1  synchronous; re-admits all channels, clears streaks and err_count.
- out_valid  out  1  one-cycle pulse, out_data valid.
- out_data  out  WIDTH  voted word.
- out_tie  out  1  at least one bit of the vote was tied (held with out_data).
- mismatch  out  CHANNELS  per-channel disagreement for the sample in out_data.
- fault  out  CHANNELS  channel currently excluded.
- err_count  out  CNT_W  samples with any active-channel mismatch, saturating.

## Operation
- Active set A = channels with fault=0; n = popcount(A).
- Per bit: ones = number of active channels with bit=1. Result bit = 1 if 2*ones > n; 0 otherwise. If 2*ones == n, result bit = 0 and out_tie = 1 for that sample.
- Mismatch[k] = 1 iff channel k is active and its word != voted word. Excluded channels always report mismatch=0.
- Per-channel FSM, advanced only on accepted samples (in_valid=1, clear_faults=0):
  - HEALTHY: mismatch -> SUSPECT with streak=1 (or FAULTY directly if FAULT_LIMIT=1); match stays HEALTHY.
  - SUSPECT: match -> HEALTHY, streak=0; mismatch -> streak+1; when streak reaches FAULT_LIMIT -> FAULTY.
  - FAULTY: absorbing until clear_faults or reset.
- Exclusion floor: a transition to FAULTY is blocked if it would leave n<2; the channel stays SUSPECT with streak saturated at FAULT_LIMIT. When several channels reach the limit on the same sample, admit them into FAULTY in ascending index order until the floor stops further exclusions.
- err_count increments by 1 per accepted sample with any mismatch bit set; saturates at 2^CNT_W-1.
- clear_faults: all FSMs -> HEALTHY, streak=0, err_count=0 at the next edge. If asserted together with in_valid, the sample is still voted and output using the pre-clear active set, but its mismatches do not update FSMs or err_count (clear wins).

## Timing
- Reset values: out_valid=0, out_data=0, out_tie=0, mismatch=0, fault=0, err_count=0, all FSMs HEALTHY, streak=0.
- Latency: 1 cycle. in_valid at edge t -> out_valid, out_data, out_tie, mismatch registered at edge t, visible in cycle t+1.
- fault and err_count update at the same edge as the output. A channel excluded by sample t is out of the vote from sample t+1 onward.
- No backpressure. Back-to-back in_valid gives back-to-back out_valid. When in_valid=0, out_valid=0 and the data outputs hold their last values.
- Reset asserted mid-stream clears all state immediately, asynchronously. Any in-flight sample is dropped, with no out_valid pulse after reset.

## Test plan
- Reset then all-agree: CHANNELS=3, WIDTH=8, words A5,A5,A5 -> next cycle out_valid=1, out_data=A5, mismatch=000, out_tie=0, err_count=0.
- Single bad channel: words 3C,3C,FF -> out_data=3C, mismatch=100, err_count=1. Repeat until 4 consecutive samples (FAULT_LIMIT=4) -> fault=100 after the 4th; the 5th sample with 3C,3C,00 gives mismatch=000.
- Streak reset: channel 0 mismatches 3 times, matches once, then mismatches 3 times -> fault stays 000.
- Tie after exclusion: fault=100, channels 0..1 = F0 and 0F -> out_data=00, out_tie=1, mismatch=011. Exclusion floor holds: after 4 more such samples fault remains 100.
- clear_faults with in_valid: fault=100, clear_faults=1 with a mismatching sample -> that sample voted with channel 2 excluded, then fault=000, err_count=0 next cycle. Saturation: CNT_W=2 and 5 mismatching samples -> err_count=3.
- Async reset mid-stream: rst_n low between edges with in_valid high -> all outputs 0 immediately, and no out_valid pulse after release.
